// File: rtl/result_browser_pkg.sv
// Shared types and helpers for the result browser: browse state and index-width function.
package result_browser_pkg;

  typedef enum logic {
    EMPTY  = 1'b0,
    BROWSE = 1'b1
  } state_t;

  // Index width that never collapses to zero bits for a single-entry dimension.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/result_browser_index_counter.sv
// 2-D row/col up/down counter with wrap-around and a registered one-cycle wrap pulse.
module browse_index_counter
  import result_browser_pkg::*;
#(
  parameter int ROWS = 2,
  parameter int COLS = 2,
  localparam int RW = idx_w(ROWS),
  localparam int CW = idx_w(COLS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          step_up,
  input  logic          step_down,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          wrap,
  output logic [RW-1:0] row_nxt,
  output logic [CW-1:0] col_nxt
);

  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  logic wrap_nxt;

  // Simultaneous up and down cancel out; clear always wins.
  always_comb begin
    row_nxt  = row;
    col_nxt  = col;
    wrap_nxt = 1'b0;
    if (clear) begin
      row_nxt = '0;
      col_nxt = '0;
    end else if (step_up && !step_down) begin
      if (col == COL_LAST) begin
        col_nxt = '0;
        if (row == ROW_LAST) begin
          row_nxt  = '0;
          wrap_nxt = 1'b1;
        end else begin
          row_nxt = row + 1'b1;
        end
      end else begin
        col_nxt = col + 1'b1;
      end
    end else if (step_down && !step_up) begin
      if (col == '0) begin
        col_nxt = COL_LAST;
        if (row == '0) begin
          row_nxt  = ROW_LAST;
          wrap_nxt = 1'b1;
        end else begin
          row_nxt = row - 1'b1;
        end
      end else begin
        col_nxt = col - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row  <= '0;
      col  <= '0;
      wrap <= 1'b0;
    end else begin
      row  <= row_nxt;
      col  <= col_nxt;
      wrap <= wrap_nxt;
    end
  end

endmodule

// File: rtl/result_browser.sv
// Snapshots the result matrix on an out_ready rise and steps through its elements.
// Auto-scroll is built only when RESULT_BROWSER_AUTO_EN is defined.
module result_browser
  import result_browser_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int ROWS        = 2,
  parameter int COLS        = 2,
  parameter int AUTO_PERIOD = 50000000,
  localparam int RW = idx_w(ROWS),
  localparam int CW = idx_w(COLS)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          out_ready,
  input  logic [ROWS*COLS*DATA_WIDTH-1:0] matrix_i,
  input  logic                          next_i,
  input  logic                          prev_i,
  input  logic                          auto_i,
  output logic [DATA_WIDTH-1:0]         sel_data,
  output logic [RW-1:0]                 row_idx,
  output logic [CW-1:0]                 col_idx,
  output logic                          sel_valid,
  output logic                          wrap_o
);

  state_t                state;
  logic                  ready_q;
  logic [DATA_WIDTH-1:0] buffer [ROWS][COLS];
  logic                  rise;
  logic                  fall;
  logic                  clear;
  logic                  step_up;
  logic [RW-1:0]         row_nxt;
  logic [CW-1:0]         col_nxt;
  logic                  auto_tick;

  assign rise  = (state == EMPTY) && out_ready && !ready_q;
  assign fall  = ready_q && !out_ready;
  assign clear = rise || fall || (state != BROWSE);

`ifdef RESULT_BROWSER_AUTO_EN
  localparam int CNT_W = $clog2(AUTO_PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AUTO_PERIOD - 1);

  logic [CNT_W-1:0] auto_cnt;

  assign auto_tick = (state == BROWSE) && auto_i && !fall && (auto_cnt == CNT_LAST);

  // Any manual step restarts the period so the next auto step is a full period away.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      auto_cnt <= '0;
    end else if (clear || !auto_i || next_i || prev_i || auto_tick) begin
      auto_cnt <= '0;
    end else begin
      auto_cnt <= auto_cnt + 1'b1;
    end
  end
`else
  logic unused_auto;
  assign unused_auto = auto_i;
  assign auto_tick   = 1'b0;
`endif

  assign step_up = next_i || auto_tick;

  browse_index_counter #(
    .ROWS(ROWS),
    .COLS(COLS)
  ) u_index (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (clear),
    .step_up  (step_up),
    .step_down(prev_i),
    .row      (row_idx),
    .col      (col_idx),
    .wrap     (wrap_o),
    .row_nxt  (row_nxt),
    .col_nxt  (col_nxt)
  );

  // sel_data is looked up with the counter's next index so it lines up with row_idx/col_idx.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= EMPTY;
      ready_q   <= 1'b0;
      buffer    <= '{default: '0};
      sel_data  <= '0;
      sel_valid <= 1'b0;
    end else begin
      ready_q <= out_ready;
      if (rise) begin
        for (int r = 0; r < ROWS; r++) begin
          for (int c = 0; c < COLS; c++) begin
            buffer[r][c] <= matrix_i[(r*COLS+c)*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        state     <= BROWSE;
        sel_data  <= matrix_i[0 +: DATA_WIDTH];
        sel_valid <= 1'b1;
      end else if (state == BROWSE && !fall) begin
        sel_data  <= buffer[row_nxt][col_nxt];
        sel_valid <= 1'b1;
      end else begin
        state     <= EMPTY;
        sel_data  <= '0;
        sel_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_result_browser.sv
// Directed self-checking bench for result_browser (2x2, 16-bit elements, AUTO_PERIOD=4).
module tb_result_browser;

  localparam int DW = 16;
  localparam int ROWS = 2;
  localparam int COLS = 2;

  logic                    clk;
  logic                    reset_n;
  logic                    out_ready;
  logic [ROWS*COLS*DW-1:0] matrix_i;
  logic                    next_i;
  logic                    prev_i;
  logic                    auto_i;
  logic [DW-1:0]           sel_data;
  logic [0:0]              row_idx;
  logic [0:0]              col_idx;
  logic                    sel_valid;
  logic                    wrap_o;

  int errors = 0;
  int checks = 0;

  result_browser #(
    .DATA_WIDTH (DW),
    .ROWS       (ROWS),
    .COLS       (COLS),
    .AUTO_PERIOD(4)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .out_ready(out_ready),
    .matrix_i (matrix_i),
    .next_i   (next_i),
    .prev_i   (prev_i),
    .auto_i   (auto_i),
    .sel_data (sel_data),
    .row_idx  (row_idx),
    .col_idx  (col_idx),
    .sel_valid(sel_valid),
    .wrap_o   (wrap_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [15:0] d, input logic r, input logic c,
                           input logic v, input logic w);
    check({tag, ".data"},  32'(sel_data),  32'(d));
    check({tag, ".row"},   32'(row_idx),   32'(r));
    check({tag, ".col"},   32'(col_idx),   32'(c));
    check({tag, ".valid"}, 32'(sel_valid), 32'(v));
    check({tag, ".wrap"},  32'(wrap_o),    32'(w));
  endtask

  task automatic pulse_next();
    next_i = 1'b1;
    tick(1);
    next_i = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    out_ready = 1'b0;
    next_i    = 1'b0;
    prev_i    = 1'b0;
    auto_i    = 1'b0;
    matrix_i  = {16'h0044, 16'h0033, 16'h0022, 16'h0011};
    #12;
    check_out("reset", 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    tick(2);
    check_out("idle", 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    out_ready = 1'b1;
    tick(1);
    check_out("snap", 16'h0011, 1'b0, 1'b0, 1'b1, 1'b0);
    matrix_i = {16'hA4A4, 16'hA3A3, 16'hA2A2, 16'hA1A1};
    tick(2);
    check_out("snap_hold", 16'h0011, 1'b0, 1'b0, 1'b1, 1'b0);

    pulse_next();
    check_out("next1", 16'h0022, 1'b0, 1'b1, 1'b1, 1'b0);
    pulse_next();
    check_out("next2", 16'h0033, 1'b1, 1'b0, 1'b1, 1'b0);
    pulse_next();
    check_out("next3", 16'h0044, 1'b1, 1'b1, 1'b1, 1'b0);
    pulse_next();
    check_out("next4", 16'h0011, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(1);
    check_out("wrap_end", 16'h0011, 1'b0, 1'b0, 1'b1, 1'b0);

    prev_i = 1'b1;
    tick(1);
    prev_i = 1'b0;
    check_out("prev_wrap", 16'h0044, 1'b1, 1'b1, 1'b1, 1'b1);
    prev_i = 1'b1;
    tick(1);
    prev_i = 1'b0;
    check_out("prev_step", 16'h0033, 1'b1, 1'b0, 1'b1, 1'b0);
    next_i = 1'b1;
    prev_i = 1'b1;
    tick(1);
    next_i = 1'b0;
    prev_i = 1'b0;
    check_out("both", 16'h0033, 1'b1, 1'b0, 1'b1, 1'b0);

    out_ready = 1'b0;
    tick(1);
    check_out("fall", 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse_next();
    check_out("empty_next", 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    matrix_i  = {16'h0044, 16'h0033, 16'h0022, 16'h0011};
    out_ready = 1'b1;
    tick(1);
    check_out("resnap", 16'h0011, 1'b0, 1'b0, 1'b1, 1'b0);

`ifdef RESULT_BROWSER_AUTO_EN
    auto_i = 1'b1;
    tick(3);
    check_out("auto_c3", 16'h0011, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(1);
    check_out("auto_c4", 16'h0022, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(1);
    check_out("auto_c5", 16'h0022, 1'b0, 1'b1, 1'b1, 1'b0);
    pulse_next();
    check_out("auto_man6", 16'h0033, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(3);
    check_out("auto_c9", 16'h0033, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(1);
    check_out("auto_c10", 16'h0044, 1'b1, 1'b1, 1'b1, 1'b0);
    auto_i = 1'b0;
    tick(8);
    check_out("auto_off", 16'h0044, 1'b1, 1'b1, 1'b1, 1'b0);
`else
    auto_i = 1'b1;
    tick(100);
    auto_i = 1'b0;
    check_out("no_auto", 16'h0011, 1'b0, 1'b0, 1'b1, 1'b0);
    pulse_next();
    check_out("pre_rst", 16'h0022, 1'b0, 1'b1, 1'b1, 1'b0);
`endif

    reset_n = 1'b0;
    #1;
    check_out("async_rst", 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    tick(1);
    check_out("rst_capture", 16'h0011, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
